pipe_trace_monitor: RTL

Synthesizable, parametrised run monitor for the multi-issue rv32i_cpu. It observes N execute lanes each cycle, maintains cycle/retire/stall counters, and detects halt (ECALL/EBREAK) and watchdog timeout with a run-state FSM. Per-cycle trace records are buffered in an internal FIFO and drained over a valid/ready port. It replaces bench-side tracing and halt logic, so the same monitor works in simulation, FPGA and emulation.

---
 rtl/rv32i_pkg.sv | 34 +++
 rtl/trace_fifo.sv | 60 ++++++
 rtl/pipe_trace_monitor.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg: shared types and constants for the pipe_trace_monitor. Rev 1.0
// PIPE_TRACE_RESULT_EN selects whether per-lane results are traced.
// ---------------------------------------------------------------------------
`default_nettype none

package rv32i_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HALTED  = 2'd2,
    TIMEOUT = 2'd3
  } mon_state_e;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  // Per-lane trace field: {valid, branch_taken, instr[, result]}.
  function automatic int lane_rec_w();
`ifdef PIPE_TRACE_RESULT_EN
    return 66;
`else
    return 34;
`endif
  endfunction

  function automatic int rec_w(input int lanes, input int cnt_w);
    return cnt_w + 2 + lanes * lane_rec_w();
  endfunction

endpackage

`default_nettype wire

// File: rtl/trace_fifo.sv
// ---------------------------------------------------------------------------
// trace_fifo: synchronous FIFO, async reset, push+pop allowed when full. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign level   = count;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the empty gate keeps the head output clean.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/pipe_trace_monitor.sv
// ---------------------------------------------------------------------------
// pipe_trace_monitor: run-state FSM, saturating counters and trace capture.
// PIPE_TRACE_RESULT_EN adds per-lane result fields to each record. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_trace_monitor
  import rv32i_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 200,
  localparam int REC_W     = rec_w(LANES, CNT_W),
  localparam int LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LANES-1:0]      lane_valid,
  input  logic [LANES*32-1:0]   lane_instr,
  input  logic [LANES*32-1:0]   lane_result,
  input  logic [LANES-1:0]      lane_branch_taken,
  input  logic                  stall,
  input  logic                  bubble,
  output logic                  trace_valid,
  input  logic                  trace_ready,
  output logic [REC_W-1:0]      trace_data,
  output logic [LVL_W-1:0]      trace_level,
  output logic [1:0]            state_o,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [CNT_W-1:0]      retired_cnt,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      drop_cnt,
  output logic                  overflow
);

  localparam int LR_W = lane_rec_w();
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);

  mon_state_e state, state_n;

  logic [LANES*LR_W-1:0] lane_fields;
  logic [LANES-1:0]      halt_lane;
  logic [REC_W-1:0]      record;
  logic [2:0]            retire_inc;
  logic                  halt_hit;
  logic                  wd_hit;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic                  drop;
  logic [CNT_W:0]        cycle_sum;
  logic [CNT_W:0]        retire_sum;
  logic [CNT_W:0]        stall_sum;
  logic [CNT_W:0]        drop_sum;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [31:0] instr;
    assign instr = lane_instr[32*i +: 32];
    assign halt_lane[i] = lane_valid[i] &&
                          ((instr == INSTR_ECALL) || (instr == INSTR_EBREAK));
`ifdef PIPE_TRACE_RESULT_EN
    assign lane_fields[LR_W*i +: LR_W] =
      {lane_valid[i], lane_branch_taken[i], instr, lane_result[32*i +: 32]};
`else
    assign lane_fields[LR_W*i +: LR_W] =
      {lane_valid[i], lane_branch_taken[i], instr};
`endif
  end

`ifndef PIPE_TRACE_RESULT_EN
  logic unused_result;
  assign unused_result = ^lane_result;
`endif

  always_comb begin
    retire_inc = '0;
    for (int i = 0; i < LANES; i++) begin
      retire_inc = retire_inc + {2'b00, lane_valid[i] & ~stall};
    end
  end

  assign halt_hit = |halt_lane;
  assign wd_hit   = (MAX_CYCLES != 0) && (cycle_cnt == WD_LAST);
  assign record   = {cycle_cnt, stall, bubble, lane_fields};
  assign push     = (state == RUN);
  assign pop      = trace_valid & trace_ready;
  assign drop     = push & full & ~pop;

  // One extra bit on each sum exposes the carry used for saturation.
  assign cycle_sum  = {1'b0, cycle_cnt}   + (CNT_W+1)'(1);
  assign retire_sum = {1'b0, retired_cnt} + (CNT_W+1)'(retire_inc);
  assign stall_sum  = {1'b0, stall_cnt}   + (CNT_W+1)'(stall);
  assign drop_sum   = {1'b0, drop_cnt}    + (CNT_W+1)'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN: begin
        if (halt_hit)    state_n = HALTED;
        else if (wd_hit) state_n = TIMEOUT;
      end
      default: state_n = state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
      stall_cnt   <= '0;
      drop_cnt    <= '0;
      overflow    <= 1'b0;
    end else if (state == RUN) begin
      cycle_cnt   <= cycle_sum[CNT_W]  ? '1 : cycle_sum[CNT_W-1:0];
      retired_cnt <= retire_sum[CNT_W] ? '1 : retire_sum[CNT_W-1:0];
      stall_cnt   <= stall_sum[CNT_W]  ? '1 : stall_sum[CNT_W-1:0];
      if (drop) begin
        drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        overflow <= 1'b1;
      end
    end
  end

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (record),
    .pop     (pop),
    .rd_data (trace_data),
    .full    (full),
    .empty   (empty),
    .level   (trace_level)
  );

  assign trace_valid = ~empty;
  assign state_o     = state;

endmodule

`default_nettype wire
